// File: rtl/range_synth_pkg.sv
// Shared definitions for the range synthesiser: FSM state encoding and
// width helpers derived from the coordinate width.
package range_synth_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DIFF,
    SQUARE,
    SUM,
    SQRT,
    STORE,
    DONE
  } state_e;

  localparam int NUM_ANCHORS = 4;

  // Signed axis delta: one extra bit so t - a never overflows
  function automatic int diffW(input int w);
    return w + 1;
  endfunction

  // Square of one delta
  function automatic int sqW(input int w);
    return 2 * w + 2;
  endfunction

  // Sum of three squares, wide enough that it can never overflow
  function automatic int sumW(input int w);
    return 2 * w + 4;
  endfunction

  // Range output width; the root of a sumW-bit value needs half as many bits
  function automatic int rangeW(input int w);
    return w + 2;
  endfunction

  // Cycles spent per anchor: DIFF + SQUARE + SUM + rangeW root steps + STORE
  function automatic int anchorCycles(input int w);
    return w + 6;
  endfunction

endpackage

// File: rtl/range_synth_isqrt_seq.sv
// Restoring integer square root, one root bit per cycle, MSB first.
// The first iteration runs on the load edge itself, so the root is final
// exactly RW edges after (and including) the load edge.
module isqrt_seq #(
  parameter int RW = 34
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_i,
  input  logic [2*RW-1:0] radicand_i,
  output logic [RW-1:0]   root_o,
  output logic            ready_o
);

  localparam int RMW = RW + 4;
  localparam int CW  = $clog2(RW + 1);

  logic [2*RW-1:0] rad_q;
  logic [RMW-1:0]  rem_q;
  logic [RW-1:0]   root_q;
  logic [CW-1:0]   cnt_q;

  logic [2*RW-1:0] srcRad;
  logic [RMW-1:0]  srcRem;
  logic [RW-1:0]   srcRoot;
  logic [RMW-1:0]  remShift;
  logic [RMW-1:0]  trial;
  logic            geq;
  logic [2*RW-1:0] rad_d;
  logic [RMW-1:0]  rem_d;
  logic [RW-1:0]   root_d;

  // One restoring step: bring down two radicand bits and try appending a 1 to the root
  always_comb begin
    srcRad   = load_i ? radicand_i : rad_q;
    srcRem   = load_i ? '0 : rem_q;
    srcRoot  = load_i ? '0 : root_q;
    remShift = (srcRem << 2) | RMW'(srcRad[2*RW-1 -: 2]);
    trial    = RMW'({srcRoot, 2'b01});
    geq      = (remShift >= trial);
    rem_d    = geq ? (remShift - trial) : remShift;
    root_d   = (srcRoot << 1) | RW'(geq);
    rad_d    = srcRad << 2;
  end

  // Iteration registers; a load restarts the root even if one is in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rad_q  <= '0;
      rem_q  <= '0;
      root_q <= '0;
      cnt_q  <= '0;
    end else if (load_i) begin
      rad_q  <= rad_d;
      rem_q  <= rem_d;
      root_q <= root_d;
      cnt_q  <= CW'(RW - 1);
    end else if (cnt_q != '0) begin
      rad_q  <= rad_d;
      rem_q  <= rem_d;
      root_q <= root_d;
      cnt_q  <= cnt_q - CW'(1);
    end
  end

  assign root_o  = root_q;
  assign ready_o = (cnt_q == '0);

endmodule

// File: rtl/range_synth.sv
// Forward range model: captures a target and four anchors, then produces
// floor(sqrt(dx^2+dy^2+dz^2)) for each anchor in turn and pulses done.
module range_synth
  import range_synth_pkg::*;
#(
  parameter int W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic signed [W-1:0]      tx,
  input  logic signed [W-1:0]      ty,
  input  logic signed [W-1:0]      tz,
  input  logic [4*W-1:0]           anc_x,
  input  logic [4*W-1:0]           anc_y,
  input  logic [4*W-1:0]           anc_z,
  output logic                     busy,
  output logic                     done,
  output logic [rangeW(W)-1:0]     r1,
  output logic [rangeW(W)-1:0]     r2,
  output logic [rangeW(W)-1:0]     r3,
  output logic [rangeW(W)-1:0]     r4
);

  localparam int RW = rangeW(W);
  localparam int DW = diffW(W);
  localparam int SW = sqW(W);
  localparam int TW = sumW(W);

  state_e                 state_q;
  logic [1:0]             idx_q;
  logic                   busy_q;
  logic                   done_q;
  logic signed [W-1:0]    tx_q, ty_q, tz_q;
  logic [4*W-1:0]         ancX_q, ancY_q, ancZ_q;
  logic signed [DW-1:0]   dx_q, dy_q, dz_q;
  logic [SW-1:0]          sqX_q, sqY_q, sqZ_q;
  logic [RW-1:0]          r_q [NUM_ANCHORS];

  logic [W-1:0]           ax, ay, az;
  logic signed [DW-1:0]   dx_d, dy_d, dz_d;
  logic signed [SW-1:0]   dxExt, dyExt, dzExt;
  logic signed [SW-1:0]   sqX_d, sqY_d, sqZ_d;
  logic [TW-1:0]          sum_d;
  logic                   sqrtLoad;
  logic [RW-1:0]          root;
  logic                   sqrtReady;

  // Datapath for the current anchor: deltas from captured coordinates, squares, and their sum
  always_comb begin
    ax    = ancX_q[32'(idx_q) * W +: W];
    ay    = ancY_q[32'(idx_q) * W +: W];
    az    = ancZ_q[32'(idx_q) * W +: W];
    dx_d  = {tx_q[W-1], tx_q} - {ax[W-1], ax};
    dy_d  = {ty_q[W-1], ty_q} - {ay[W-1], ay};
    dz_d  = {tz_q[W-1], tz_q} - {az[W-1], az};
    dxExt = SW'(dx_q);
    dyExt = SW'(dy_q);
    dzExt = SW'(dz_q);
    sqX_d = dxExt * dxExt;
    sqY_d = dyExt * dyExt;
    sqZ_d = dzExt * dzExt;
    sum_d = TW'(sqX_q) + TW'(sqY_q) + TW'(sqZ_q);
  end

  assign sqrtLoad = (state_q == SUM);

  isqrt_seq #(
    .RW(RW)
  ) u_isqrt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (sqrtLoad),
    .radicand_i (sum_d),
    .root_o     (root),
    .ready_o    (sqrtReady)
  );

  // Sequencer: capture on accept, walk the four anchors, then pulse done on leaving DONE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      tx_q    <= '0;
      ty_q    <= '0;
      tz_q    <= '0;
      ancX_q  <= '0;
      ancY_q  <= '0;
      ancZ_q  <= '0;
      dx_q    <= '0;
      dy_q    <= '0;
      dz_q    <= '0;
      sqX_q   <= '0;
      sqY_q   <= '0;
      sqZ_q   <= '0;
      for (int i = 0; i < NUM_ANCHORS; i++) r_q[i] <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            tx_q    <= tx;
            ty_q    <= ty;
            tz_q    <= tz;
            ancX_q  <= anc_x;
            ancY_q  <= anc_y;
            ancZ_q  <= anc_z;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= DIFF;
          end
        end
        DIFF: begin
          dx_q    <= dx_d;
          dy_q    <= dy_d;
          dz_q    <= dz_d;
          state_q <= SQUARE;
        end
        SQUARE: begin
          sqX_q   <= sqX_d;
          sqY_q   <= sqY_d;
          sqZ_q   <= sqZ_d;
          state_q <= SUM;
        end
        SUM: begin
          state_q <= SQRT;
        end
        SQRT: begin
          if (sqrtReady) state_q <= STORE;
        end
        STORE: begin
          r_q[idx_q] <= root;
          if (idx_q == 2'(NUM_ANCHORS - 1)) begin
            state_q <= DONE;
          end else begin
            idx_q   <= idx_q + 2'd1;
            state_q <= DIFF;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign r1   = r_q[0];
  assign r2   = r_q[1];
  assign r3   = r_q[2];
  assign r4   = r_q[3];

endmodule
